// File: rtl/timer_ctrl.sv
// Programmable up-counter timer with one-shot/periodic modes, sticky
// terminal-count interrupt and overrun detection.
module timer_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         cfg_we,
  input  logic [W-1:0] cfg_period,
  input  logic         cfg_mode,
  input  logic         start,
  input  logic         stop,
  input  logic         irq_ack,
  output logic [W-1:0] count,
  output logic         busy,
  output logic         irq,
  output logic         overrun
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]   r_state;
  logic [W-1:0] r_count;
  logic [W-1:0] r_period;
  logic         r_mode;
  logic         r_irq;
  logic         r_overrun;

  logic [1:0]   w_state_nxt;
  logic [W-1:0] w_count_nxt;
  logic [W-1:0] w_period_nxt;
  logic         w_mode_nxt;
  logic         w_irq_nxt;
  logic         w_overrun_nxt;
  logic         w_cfg_accept;
  logic         w_terminal;

  // A stop in the terminal cycle aborts the run, so it raises no irq.
  assign w_cfg_accept = cfg_we && (r_state != ST_RUN);
  assign w_terminal   = (r_state == ST_RUN) && (r_count == r_period) && !stop;

  // Next-state, counter and flag computation.
  always_comb begin
    w_state_nxt   = r_state;
    w_count_nxt   = r_count;
    w_period_nxt  = r_period;
    w_mode_nxt    = r_mode;
    w_irq_nxt     = r_irq;
    w_overrun_nxt = r_overrun;

    if (w_cfg_accept) begin
      w_period_nxt  = cfg_period;
      w_mode_nxt    = cfg_mode;
      w_overrun_nxt = 1'b0;
    end else begin
      w_period_nxt  = r_period;
    end

    case (r_state)
      ST_IDLE: begin
        w_count_nxt = {W{1'b0}};
        if (stop) begin
          w_state_nxt = ST_IDLE;
        end else if (start && (r_period != {W{1'b0}})) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = {W{1'b0}};
        end else if (r_count == r_period) begin
          if (r_mode) begin
            w_count_nxt = {W{1'b0}};
          end else begin
            w_state_nxt = ST_DONE;
          end
        end else begin
          w_count_nxt = r_count + {{(W-1){1'b0}}, 1'b1};
        end
      end
      ST_DONE: begin
        if (stop) begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = {W{1'b0}};
        end else if (start) begin
          w_state_nxt = ST_RUN;
          w_count_nxt = {W{1'b0}};
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_count_nxt = {W{1'b0}};
      end
    endcase

    // An ack coinciding with a new terminal loses; the flag stays set.
    if (w_terminal) begin
      w_irq_nxt = 1'b1;
      if (r_irq && !irq_ack) begin
        w_overrun_nxt = 1'b1;
      end else begin
        w_overrun_nxt = w_overrun_nxt;
      end
    end else if (irq_ack) begin
      w_irq_nxt = 1'b0;
    end else begin
      w_irq_nxt = r_irq;
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_count   <= {W{1'b0}};
      r_period  <= {W{1'b0}};
      r_mode    <= 1'b0;
      r_irq     <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_count   <= w_count_nxt;
      r_period  <= w_period_nxt;
      r_mode    <= w_mode_nxt;
      r_irq     <= w_irq_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  assign count   = r_count;
  assign busy    = (r_state == ST_RUN);
  assign irq     = r_irq;
  assign overrun = r_overrun;

endmodule

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 Parameter W, default 4: width of period register and count output.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset; 0 forces all state to reset values immediately.
REQ-004 cfg_we  input  1  config write strobe; accepted only in IDLE or DONE.
REQ-005 cfg_period  input  W  terminal count value, latched on accepted cfg_we.
REQ-006 cfg_mode  input  1  0 = one-shot, 1 = periodic, latched with cfg_period.
REQ-007 start  input  1  single-cycle request to begin counting.
REQ-008 stop  input  1  single-cycle request to abort counting.
REQ-009 irq_ack  input  1  clears irq.
REQ-010 count  output  W  current counter value, registered.
REQ-011 busy  output  1  1 while in RUN.
REQ-012 irq  output  1  sticky terminal-count flag, registered.
REQ-013 overrun  output  1  sticky flag: terminal reached while irq still pending.

Function
REQ-014 States: IDLE, RUN, DONE; busy = (state == RUN), decoded from state register.
REQ-015 cfg_we in IDLE/DONE latches period and mode at the edge and clears overrun; cfg_we in RUN is ignored, with no state change.
REQ-016 IDLE: count = 0; start with latched period != 0 -> RUN next cycle, count stays 0; start with period == 0 is ignored.
REQ-017 RUN, count != period: count <= count + 1 (W-bit, no wrap possible since count <= period).
REQ-018 RUN, count == period (terminal): irq <= 1; periodic mode -> count <= 0, stay RUN; one-shot -> DONE, count holds at period.
REQ-019 Period interval is period+1 cycles: irq rises on the edge after count first shows period.
REQ-020 DONE: count holds; start -> RUN with count <= 0; stop -> IDLE with count <= 0.
REQ-021 stop in RUN -> IDLE, count <= 0 next cycle; irq and overrun unaffected.
REQ-022 start and stop asserted in the same cycle: stop wins in every state.
REQ-023 start in RUN is ignored.
REQ-024 irq_ack with no terminal in the same cycle -> irq <= 0.
REQ-025 Terminal with irq == 1 and irq_ack == 0 -> overrun <= 1, irq stays 1.
REQ-026 Terminal and irq_ack in the same cycle -> irq stays 1, overrun unchanged.
REQ-027 overrun clears only on reset or an accepted cfg_we.

Reset
REQ-028 While reset == 0: state = IDLE, count = 0, period = 0, mode = 0, irq = 0, overrun = 0, busy = 0.
REQ-029 Reset asserted mid-RUN takes effect asynchronously, with no terminal or irq generated.
REQ-030 After reset deasserts, the first edge is evaluated normally from IDLE, and start is ignored until a nonzero period is configured.

Verification
REQ-031 Stimulus: cfg_we period=3 mode=1, start, run 12 cycles. Required response: count sequence 0,1,2,3,0,1,2,3...; irq first rises 4 cycles after entering RUN.
REQ-032 Stimulus: period=2 mode=0, start. Required response: count 0,1,2; then DONE with count held at 2, busy=0, irq=1; irq_ack -> irq=0; stop -> count=0.
REQ-033 Stimulus: periodic period=1, no irq_ack. Required response: second terminal sets overrun=1; cfg_we after stop clears it.
REQ-034 Stimulus: irq_ack coincident with terminal. Required response: irq stays 1, overrun stays 0.
REQ-035 Stimulus: start and stop in the same cycle from IDLE and from DONE. Required response: state IDLE, count=0.
REQ-036 Stimulus: reset pulled low mid-RUN at count=2. Required response: count=0, busy=0, irq=0 immediately, before any clock edge; period=0 after release, so start is ignored.
